// File: rtl/armleocpu_ptw_sequencer_pkg.sv
// Shared types and constants for the Sv32 page-table walker.
// PTE bit positions, walker states, bus response codes.
package armleocpu_ptw_sequencer_pkg;

  localparam int unsigned PteV = 0;
  localparam int unsigned PteR = 1;
  localparam int unsigned PteW = 2;
  localparam int unsigned PteX = 3;
  localparam int unsigned PteU = 4;
  localparam int unsigned PteG = 5;
  localparam int unsigned PteA = 6;
  localparam int unsigned PteD = 7;

  localparam logic [1:0] BusOkay = 2'b00;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StL1   = 2'd1,
    StL0   = 2'd2,
    StDone = 2'd3
  } ptw_state_e;

  typedef struct packed {
    logic valid;       // V set and not the reserved W-without-R encoding
    logic leaf;        // R or X set
    logic misaligned;  // PPN0 field nonzero, illegal for a superpage leaf
  } pte_decode_t;

endpackage

// File: rtl/armleocpu_ptw_pte_decode.sv
// Combinational PTE classifier: structural validity, leaf detection and superpage alignment.
module armleocpu_ptw_pte_decode
  import armleocpu_ptw_sequencer_pkg::*;
(
  input  logic [31:0] pte,
  output pte_decode_t decoded
);

  // PPN1 and the U/G/A/D/RSW fields do not affect classification.
  logic unused_pte_bits;
  assign unused_pte_bits = ^{pte[31:20], pte[9:4]};

  always_comb begin
    decoded            = '0;
    decoded.valid      = pte[PteV] && !(!pte[PteR] && pte[PteW]);
    decoded.leaf       = pte[PteR] || pte[PteX];
    decoded.misaligned = |pte[19:10];
  end

endmodule

// File: rtl/armleocpu_ptw_sequencer.sv
// Sv32 two-level page-table walker: reads level-1 then level-0 PTEs over the memory port
// and returns the PPN plus PTE[7:0] for the TLB; reports structural and bus faults only.
module armleocpu_ptw_sequencer
  import armleocpu_ptw_sequencer_pkg::*;
#(
  parameter bit CHECK_SUPERPAGE_ALIGN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [21:0] satp_ppn,
  input  logic        resolve_request,
  input  logic [19:0] resolve_virtual_address,
  output logic        resolve_ack,
  output logic        resolve_done,
  output logic        resolve_pagefault,
  output logic        resolve_accessfault,
  output logic [21:0] resolve_physical_address,
  output logic [7:0]  resolve_access_bits,
  output logic        m_transaction,
  output logic        m_cmd,
  output logic [33:0] m_address,
  input  logic        m_transaction_done,
  input  logic [1:0]  m_transaction_response,
  input  logic [31:0] m_rdata
);

  ptw_state_e state_q, state_d;

  logic [21:0] satp_q;
  logic [9:0]  vpn1_q, vpn0_q;
  logic [21:0] pte_ppn_q;
  logic        pagefault_q, accessfault_q;
  logic [21:0] ppn_q;
  logic [7:0]  bits_q;

  pte_decode_t pte_dec;

  armleocpu_ptw_pte_decode u_pte_decode (
    .pte     (m_rdata),
    .decoded (pte_dec)
  );

  logic accept;
  logic pte_returned;
  logic t_terminal, t_pagefault, t_accessfault;
  logic [21:0] t_ppn;
  logic [7:0]  t_bits;

  assign accept       = (state_q == StIdle) && resolve_request;
  assign pte_returned = ((state_q == StL1) || (state_q == StL0)) && m_transaction_done;

  // Outcome of the PTE currently on m_rdata, in fault-priority order.
  always_comb begin
    t_terminal    = 1'b1;
    t_pagefault   = 1'b0;
    t_accessfault = 1'b0;
    t_ppn         = '0;
    t_bits        = '0;
    if (m_transaction_response != BusOkay) begin
      t_accessfault = 1'b1;
    end else if (!pte_dec.valid) begin
      t_pagefault = 1'b1;
    end else if (pte_dec.leaf) begin
      if (state_q == StL1) begin
        if (CHECK_SUPERPAGE_ALIGN && pte_dec.misaligned) begin
          t_pagefault = 1'b1;
        end else begin
          t_ppn  = {m_rdata[31:20], vpn0_q};
          t_bits = m_rdata[7:0];
        end
      end else begin
        t_ppn  = m_rdata[31:10];
        t_bits = m_rdata[7:0];
      end
    end else if (state_q == StL1) begin
      t_terminal = 1'b0;
    end else begin
      t_pagefault = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (accept) state_d = StL1;
      StL1:   if (pte_returned) state_d = t_terminal ? StDone : StL0;
      StL0:   if (pte_returned) state_d = StDone;
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    resolve_ack   = accept;
    resolve_done  = (state_q == StDone);
    m_transaction = (state_q == StL1) || (state_q == StL0);
    m_cmd         = 1'b0;
    m_address     = (state_q == StL0) ? {pte_ppn_q, vpn0_q, 2'b00} : {satp_q, vpn1_q, 2'b00};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      satp_q        <= '0;
      vpn1_q        <= '0;
      vpn0_q        <= '0;
      pte_ppn_q     <= '0;
      pagefault_q   <= 1'b0;
      accessfault_q <= 1'b0;
      ppn_q         <= '0;
      bits_q        <= '0;
    end else if (accept) begin
      satp_q        <= satp_ppn;
      vpn1_q        <= resolve_virtual_address[19:10];
      vpn0_q        <= resolve_virtual_address[9:0];
      pagefault_q   <= 1'b0;
      accessfault_q <= 1'b0;
      ppn_q         <= '0;
      bits_q        <= '0;
    end else if (pte_returned) begin
      if (t_terminal) begin
        pagefault_q   <= t_pagefault;
        accessfault_q <= t_accessfault;
        ppn_q         <= t_ppn;
        bits_q        <= t_bits;
      end else begin
        pte_ppn_q <= m_rdata[31:10];
      end
    end
  end

  assign resolve_pagefault        = pagefault_q;
  assign resolve_accessfault      = accessfault_q;
  assign resolve_physical_address = ppn_q;
  assign resolve_access_bits      = bits_q;

endmodule

// File: tb/tb_armleocpu_ptw_sequencer.sv
// Directed self-checking bench for the Sv32 page-table walker.
module tb_armleocpu_ptw_sequencer;

  logic        clk;
  logic        rst_n;
  logic [21:0] satp_ppn;
  logic        resolve_request;
  logic [19:0] resolve_virtual_address;
  logic        resolve_ack;
  logic        resolve_done;
  logic        resolve_pagefault;
  logic        resolve_accessfault;
  logic [21:0] resolve_physical_address;
  logic [7:0]  resolve_access_bits;
  logic        m_transaction;
  logic        m_cmd;
  logic [33:0] m_address;
  logic        m_transaction_done;
  logic [1:0]  m_transaction_response;
  logic [31:0] m_rdata;

  armleocpu_ptw_sequencer #(.CHECK_SUPERPAGE_ALIGN(1'b1)) dut (
    .clk                      (clk),
    .rst_n                    (rst_n),
    .satp_ppn                 (satp_ppn),
    .resolve_request          (resolve_request),
    .resolve_virtual_address  (resolve_virtual_address),
    .resolve_ack              (resolve_ack),
    .resolve_done             (resolve_done),
    .resolve_pagefault        (resolve_pagefault),
    .resolve_accessfault      (resolve_accessfault),
    .resolve_physical_address (resolve_physical_address),
    .resolve_access_bits      (resolve_access_bits),
    .m_transaction            (m_transaction),
    .m_cmd                    (m_cmd),
    .m_address                (m_address),
    .m_transaction_done       (m_transaction_done),
    .m_transaction_response   (m_transaction_response),
    .m_rdata                  (m_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_asserts = 0;
  int n_fail = 0;

  // Bus response script, consumed in read order within one walk() call.
  logic [31:0] q_data[4];
  logic [1:0]  q_resp[4];
  int          q_n;

  // Observations of the last walk() call.
  logic [33:0] addr_seen[4];
  int n_reads, addr_unstable, n_ack, n_done;
  int ack_cyc[2];
  int done_cyc[2];
  logic        cap_pf, cap_af;
  logic [21:0] cap_ppn;
  logic [7:0]  cap_bits;

  task automatic walk(input logic [19:0] va, input logic hold, input int want_dones,
                      input int wait_states);
    int wc = 0;
    int tail = -1;
    logic in_txn = 1'b0;
    logic finished = 1'b0;
    logic [33:0] cur_addr = '0;
    n_reads = 0; addr_unstable = 0; n_ack = 0; n_done = 0;
    ack_cyc[0] = -1; ack_cyc[1] = -1; done_cyc[0] = -1; done_cyc[1] = -1;
    resolve_virtual_address = va;
    @(posedge clk); #1;
    resolve_request = 1'b1;
    for (int i = 0; i < 200 && !finished; i++) begin
      @(negedge clk);
      if (resolve_ack) begin
        if (n_ack < 2) ack_cyc[n_ack] = cyc;
        n_ack++;
      end
      if (m_transaction) begin
        if (!in_txn) begin
          in_txn = 1'b1;
          cur_addr = m_address;
        end else if (m_address !== cur_addr) begin
          addr_unstable++;
        end
        if (wc == wait_states) begin
          m_transaction_done = 1'b1;
          m_rdata = (n_reads < q_n) ? q_data[n_reads] : 32'h0;
          m_transaction_response = (n_reads < q_n) ? q_resp[n_reads] : 2'b00;
          if (n_reads < 4) addr_seen[n_reads] = m_address;
          n_reads++;
          wc = 0;
          in_txn = 1'b0;
        end else begin
          wc++;
        end
      end
      if (resolve_done) begin
        if (n_done == 0) begin
          cap_pf = resolve_pagefault;
          cap_af = resolve_accessfault;
          cap_ppn = resolve_physical_address;
          cap_bits = resolve_access_bits;
        end
        if (n_done < 2) done_cyc[n_done] = cyc;
        n_done++;
        if (n_done == want_dones) begin
          resolve_request = 1'b0;
          tail = 3;
        end
      end
      if (tail > 0) begin
        tail--;
        if (tail == 0) finished = 1'b1;
      end
      @(posedge clk); #1;
      m_transaction_done = 1'b0;
      if (!hold && n_ack > 0) resolve_request = 1'b0;
    end
    n_asserts++;
    if (!finished) begin
      n_fail++;
      $display("FAIL walk_timeout: dones=%0d required=%0d", n_done, want_dones);
      resolve_request = 1'b0;
    end
  endtask

  task automatic do_reset();
    resolve_request = 1'b0;
    m_transaction_done = 1'b0;
    m_transaction_response = 2'b00;
    m_rdata = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    n_asserts += 6;
    if (m_transaction !== 1'b0) begin n_fail++; $display("FAIL reset_mtxn: got %b want 0", m_transaction); end
    if (resolve_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", resolve_done); end
    if (resolve_pagefault !== 1'b0 || resolve_accessfault !== 1'b0) begin
      n_fail++; $display("FAIL reset_faults: got pf=%b af=%b want 0 0", resolve_pagefault, resolve_accessfault);
    end
    if (resolve_physical_address !== 22'h0) begin n_fail++; $display("FAIL reset_ppn: got %h want 0", resolve_physical_address); end
    if (resolve_access_bits !== 8'h0) begin n_fail++; $display("FAIL reset_bits: got %h want 0", resolve_access_bits); end
    if (resolve_ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %b want 0", resolve_ack); end
  endtask

  task automatic test_4k_page();
    q_data[0] = 32'h0040_0001; q_resp[0] = 2'b00;
    q_data[1] = 32'h0ABC_D0CF; q_resp[1] = 2'b00; q_n = 2;
    walk(20'h12345, 1'b0, 1, 0);
    n_asserts += 8;
    if (addr_seen[0] !== 34'h0_0010_0120) begin n_fail++; $display("FAIL 4k_l1_addr: got %h want 000100120", addr_seen[0]); end
    if (addr_seen[1] !== 34'h0_0100_0D14) begin n_fail++; $display("FAIL 4k_l0_addr: got %h want 001000d14", addr_seen[1]); end
    if (cap_ppn !== 22'h02AF34) begin n_fail++; $display("FAIL 4k_ppn: got %h want 02af34", cap_ppn); end
    if (cap_bits !== 8'hCF) begin n_fail++; $display("FAIL 4k_bits: got %h want cf", cap_bits); end
    if (cap_pf !== 1'b0 || cap_af !== 1'b0) begin n_fail++; $display("FAIL 4k_faults: got pf=%b af=%b want 0 0", cap_pf, cap_af); end
    if (done_cyc[0] - ack_cyc[0] != 3) begin n_fail++; $display("FAIL 4k_latency: got %0d want 3", done_cyc[0] - ack_cyc[0]); end
    if (n_reads != 2) begin n_fail++; $display("FAIL 4k_reads: got %0d want 2", n_reads); end
    if (n_ack != 1 || n_done != 1) begin n_fail++; $display("FAIL 4k_handshake: got ack=%0d done=%0d want 1 1", n_ack, n_done); end
  endtask

  task automatic test_superpage();
    q_data[0] = 32'h2000_00CF; q_resp[0] = 2'b00; q_n = 1;
    walk(20'h12345, 1'b0, 1, 0);
    n_asserts += 4;
    if (cap_ppn !== 22'h080345) begin n_fail++; $display("FAIL super_ppn: got %h want 080345", cap_ppn); end
    if (cap_bits !== 8'hCF || cap_pf !== 1'b0) begin n_fail++; $display("FAIL super_bits: got %h pf=%b want cf 0", cap_bits, cap_pf); end
    if (done_cyc[0] - ack_cyc[0] != 2) begin n_fail++; $display("FAIL super_latency: got %0d want 2", done_cyc[0] - ack_cyc[0]); end
    if (n_reads != 1) begin n_fail++; $display("FAIL super_reads: got %0d want 1", n_reads); end
  endtask

  task automatic test_misaligned();
    q_data[0] = 32'h2000_04CF; q_resp[0] = 2'b00; q_n = 1;
    walk(20'h12345, 1'b0, 1, 0);
    n_asserts += 2;
    if (cap_pf !== 1'b1 || cap_af !== 1'b0) begin n_fail++; $display("FAIL misalign_faults: got pf=%b af=%b want 1 0", cap_pf, cap_af); end
    if (cap_ppn !== 22'h0 || cap_bits !== 8'h0) begin n_fail++; $display("FAIL misalign_result: got %h %h want 0 0", cap_ppn, cap_bits); end
  endtask

  task automatic test_pagefaults();
    logic [31:0] l1_pte[3] = '{32'h0000_0000, 32'h0000_0005, 32'h0040_0001};
    int exp_reads[3] = '{1, 1, 2};
    for (int k = 0; k < 3; k++) begin
      q_data[0] = l1_pte[k]; q_resp[0] = 2'b00;
      q_data[1] = 32'h0000_0001; q_resp[1] = 2'b00; q_n = 2;
      walk(20'h12345, 1'b0, 1, 0);
      n_asserts += 3;
      if (cap_pf !== 1'b1 || cap_af !== 1'b0) begin n_fail++; $display("FAIL pf_flags[%0d]: got pf=%b af=%b want 1 0", k, cap_pf, cap_af); end
      if (cap_ppn !== 22'h0 || cap_bits !== 8'h0) begin n_fail++; $display("FAIL pf_result[%0d]: got %h %h want 0 0", k, cap_ppn, cap_bits); end
      if (n_reads != exp_reads[k]) begin n_fail++; $display("FAIL pf_reads[%0d]: got %0d want %0d", k, n_reads, exp_reads[k]); end
    end
  endtask

  task automatic test_accessfault();
    q_data[0] = 32'h0040_0001; q_resp[0] = 2'b00;
    q_data[1] = 32'h0ABC_D0CF; q_resp[1] = 2'b11; q_n = 2;
    walk(20'h12345, 1'b0, 1, 0);
    n_asserts += 2;
    if (cap_af !== 1'b1 || cap_pf !== 1'b0) begin n_fail++; $display("FAIL af_l0_flags: got af=%b pf=%b want 1 0", cap_af, cap_pf); end
    if (cap_ppn !== 22'h0 || cap_bits !== 8'h0) begin n_fail++; $display("FAIL af_l0_result: got %h %h want 0 0", cap_ppn, cap_bits); end
    // Bus error takes priority over an invalid PTE.
    q_data[0] = 32'h0000_0000; q_resp[0] = 2'b01; q_n = 1;
    walk(20'h00001, 1'b0, 1, 0);
    n_asserts += 2;
    if (cap_af !== 1'b1 || cap_pf !== 1'b0) begin n_fail++; $display("FAIL af_prio_flags: got af=%b pf=%b want 1 0", cap_af, cap_pf); end
    if (n_reads != 1) begin n_fail++; $display("FAIL af_prio_reads: got %0d want 1", n_reads); end
  endtask

  task automatic test_wait_states();
    q_data[0] = 32'h0040_0001; q_resp[0] = 2'b00;
    q_data[1] = 32'h0ABC_D0CF; q_resp[1] = 2'b00; q_n = 2;
    walk(20'h12345, 1'b0, 1, 2);
    n_asserts += 4;
    if (addr_unstable != 0) begin n_fail++; $display("FAIL ws_addr_stable: got %0d changes want 0", addr_unstable); end
    if (done_cyc[0] - ack_cyc[0] != 7) begin n_fail++; $display("FAIL ws_latency: got %0d want 7", done_cyc[0] - ack_cyc[0]); end
    if (cap_ppn !== 22'h02AF34) begin n_fail++; $display("FAIL ws_ppn: got %h want 02af34", cap_ppn); end
    if (m_cmd !== 1'b0) begin n_fail++; $display("FAIL ws_cmd: got %b want 0", m_cmd); end
  endtask

  task automatic test_back_to_back();
    q_data[0] = 32'h2000_00CF; q_resp[0] = 2'b00;
    q_data[1] = 32'h0000_0000; q_resp[1] = 2'b00; q_n = 2;
    walk(20'h12345, 1'b1, 2, 0);
    n_asserts += 4;
    if (n_ack != 2) begin n_fail++; $display("FAIL b2b_acks: got %0d want 2", n_ack); end
    if (ack_cyc[1] != done_cyc[0] + 1) begin n_fail++; $display("FAIL b2b_reack: got %0d want %0d", ack_cyc[1], done_cyc[0] + 1); end
    if (done_cyc[1] - ack_cyc[1] != 2) begin n_fail++; $display("FAIL b2b_latency: got %0d want 2", done_cyc[1] - ack_cyc[1]); end
    if (cap_ppn !== 22'h080345) begin n_fail++; $display("FAIL b2b_ppn: got %h want 080345", cap_ppn); end
  endtask

  task automatic test_reset_mid_walk();
    resolve_virtual_address = 20'h12345;
    @(posedge clk); #1 resolve_request = 1'b1;
    @(posedge clk); #1 resolve_request = 1'b0;
    @(negedge clk);
    m_transaction_done = 1'b1; m_rdata = 32'h0040_0001; m_transaction_response = 2'b00;
    @(posedge clk); #1 m_transaction_done = 1'b0;
    @(negedge clk);
    n_asserts += 1;
    if (m_transaction !== 1'b1 || m_address !== 34'h0_0100_0D14) begin
      n_fail++; $display("FAIL rst_l0_entry: got txn=%b addr=%h want 1 001000d14", m_transaction, m_address);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_asserts += 1;
    if (m_transaction !== 1'b0) begin n_fail++; $display("FAIL rst_async_drop: got %b want 0", m_transaction); end
    @(posedge clk);
    @(negedge clk);
    n_asserts += 1;
    if (resolve_done !== 1'b0 || m_transaction !== 1'b0) begin
      n_fail++; $display("FAIL rst_held: got done=%b txn=%b want 0 0", resolve_done, m_transaction);
    end
    rst_n = 1'b1;
    // Stray completion while idle must be ignored.
    @(posedge clk); #1 m_transaction_done = 1'b1;
    @(posedge clk); #1 m_transaction_done = 1'b0;
    @(negedge clk);
    n_asserts += 1;
    if (resolve_done !== 1'b0 || m_transaction !== 1'b0) begin
      n_fail++; $display("FAIL idle_stray_done: got done=%b txn=%b want 0 0", resolve_done, m_transaction);
    end
    q_data[0] = 32'h0040_0001; q_resp[0] = 2'b00;
    q_data[1] = 32'h0ABC_D0CF; q_resp[1] = 2'b00; q_n = 2;
    walk(20'h12345, 1'b0, 1, 0);
    n_asserts += 2;
    if (n_done != 1) begin n_fail++; $display("FAIL rst_rewalk_pulses: got %0d want 1", n_done); end
    if (cap_ppn !== 22'h02AF34 || n_reads != 2) begin
      n_fail++; $display("FAIL rst_rewalk_result: got %h reads=%0d want 02af34 2", cap_ppn, n_reads);
    end
  endtask

  initial begin
    satp_ppn = 22'h00100;
    resolve_virtual_address = '0;
    test_reset();
    test_4k_page();
    test_superpage();
    test_misaligned();
    test_pagefaults();
    test_accessfault();
    test_wait_states();
    test_back_to_back();
    test_reset_mid_walk();
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
